// File: rtl/restador_serial_4bit.sv
// ----------------------------------------------------------------------------
// restador_serial_4bit
//   Bit-serial subtractor: Diff = A - B, one bit per clock, LSB first.
//   A single full-subtractor cell and a borrow flip-flop are reused WIDTH
//   times. The operation is wrapped in a start/done handshake.
//
// Ports:
//   clk    in   1      system clock, rising edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      launch request, sampled only while idle
//   A      in   WIDTH  minuend, latched on the accepting edge
//   B      in   WIDTH  subtrahend, latched on the accepting edge
//   Diff   out  WIDTH  (A - B) mod 2^WIDTH, held until the next completion
//   Bout   out  1      final borrow, 1 when A < B (unsigned)
//   busy   out  1      high while an operation is in progress
//   done   out  1      one-cycle completion pulse
// ----------------------------------------------------------------------------
module restador_serial_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    // Counter must hold values 0..WIDTH-1; the extra bit keeps the
    // increment past the last compare from wrapping into a valid index.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_borrow_nxt;
    logic             w_last;

    // Full-subtractor cell on the current LSBs.
    assign w_a          = r_ra[0];
    assign w_b          = r_rb[0];
    assign w_d          = w_a ^ w_b ^ r_borrow;
    assign w_borrow_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    // Outputs come straight from registers only.
    assign Diff = r_diff;
    assign Bout = r_bout;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra     <= A;
                        r_rb     <= B;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_ra     <= r_ra >> 1;
                    r_rb     <= r_rb >> 1;
                    // Result bits enter at the MSB so that after WIDTH
                    // shifts the first (LSB) difference bit sits at bit 0.
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= {w_d, r_res[WIDTH-1:1]};
                        r_bout <= w_borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serial_4bit.sv
module tb_restador_serial_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    restador_serial_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_checks = n_checks + 1;
        if (got == want) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Reference model: an accepted operation keeps the block busy for W+1
    // cycles, the last of which is the done cycle, where the precomputed
    // arithmetic result becomes visible.
    int           m_phase = 0;
    logic [W-1:0] m_pd    = '0;
    logic         m_pb    = 1'b0;
    logic [W-1:0] m_diff  = '0;
    logic         m_bout  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_diff  <= '0;
            m_bout  <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_pd    <= A - B;
                m_pb    <= (A < B);
            end
        end else if (m_phase == W + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == W) begin
                m_diff <= m_pd;
                m_bout <= m_pb;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("done", int'(done), int'(m_phase == W + 1));
            chk("Diff", int'(Diff), int'(m_diff));
            chk("Bout", int'(Bout), int'(m_bout));
            if (done) n_done = n_done + 1;
        end
    end

    task automatic launch(input int a, input int b);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of negedges up to and including the done cycle,
    // and how many of them saw busy high.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (busy) nbusy = nbusy + 1;
            if (done) break;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int a, input int b, input int ed, input int eb);
        int lat;
        int nb;
        launch(a, b);
        wait_done(lat, nb);
        chk("latency", lat, W + 1);
        chk("op_diff", int'(Diff), ed);
        chk("op_bout", int'(Bout), eb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int nb;
        int d0;
        int last_t;
        int pulses;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        chk("rst_diff", int'(Diff), 0);
        chk("rst_bout", int'(Bout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First operation: latency and busy width.
        launch(9, 4);
        wait_done(lat, nb);
        chk("first_latency", lat, 5);
        chk("first_busy", nb, 5);
        chk("first_diff", int'(Diff), 5);
        chk("first_bout", int'(Bout), 0);
        @(posedge clk);
        #1;

        run_op(4, 9, 11, 1);
        run_op(0, 1, 15, 1);
        run_op(15, 15, 0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, (a - b) & 15, int'(a < b));
            end
        end

        // start during SHIFT and during DONE must be ignored.
        d0 = n_done;
        launch(12, 3);
        A     = 4'd7;
        B     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nb);
        chk("ign_diff", int'(Diff), 9);
        chk("ign_bout", int'(Bout), 0);
        A     = 4'd7;
        B     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ign_done_count", n_done - d0, 1);
        chk("ign_diff_hold", int'(Diff), 9);
        @(posedge clk);
        #1;

        // Level-held start: back-to-back operations every W+2 cycles.
        A      = 4'd3;
        B      = 4'd1;
        start  = 1'b1;
        last_t = -1;
        pulses = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) begin
                chk("held_diff", int'(Diff), 2);
                if (last_t >= 0) chk("held_period", t - last_t, 6);
                last_t = t;
                pulses = pulses + 1;
            end
        end
        chk("held_pulses", pulses, 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("held_idle", int'(busy), 0);
        @(posedge clk);
        #1;

        // Asynchronous abort mid-SHIFT.
        d0 = n_done;
        launch(8, 5);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_diff", int'(Diff), 0);
        chk("abort_bout", int'(Bout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        @(posedge clk);
        #1;
        run_op(8, 5, 3, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
